eight_bit_serial_subtractor_with_enable: RTL and testbench
==========================================================

// Module: eight_bit_serial_subtractor_with_enable
// PURPOSE
//   Bit-serial A - B - Bin0 subtractor. Inverse companion to the ripple adder datapath.
//   Processes one bit per clock, LSB first, through a single full-subtractor cell.
//   Holds the borrow in a flip-flop between bits.
//   Sits beside the adder in the arithmetic block, where area matters more than latency.
//   Uses a Start/Busy/Done handshake and the same active-low Enable / tri-state output scheme.
// PARAMETERS
//   WIDTH  8  operand and result width in bits (>=2)
// PORTS
//   Clk     in   1      single clock, rising edge
//   Rst     in   1      synchronous, active-high reset
//   Enable  in   1      active-low; 0 = block active, 1 = abort and tri-state Diff
//   Start   in   1      request; sampled only in IDLE
//   A       in   WIDTH  minuend, latched on accepted Start
//   B       in   WIDTH  subtrahend, latched on accepted Start
//   Bin0    in   1      borrow-in to bit 0, latched on accepted Start
//   Diff    out  WIDTH  result register; driven when Enable=0, else 'bz
//   Bout8   out  1      final borrow-out (MSB borrow), registered
//   Busy    out  1      high in RUN
//   Done    out  1      one-cycle pulse in DONE
// BEHAVIOUR
//   Reset: state=IDLE, count=0, borrow FF=0, Diff reg=0, Bout8=0, Busy=0, Done=0.
//   Reset dominates every other input, including mid-RUN.
//   FSM states:
//     IDLE -> RUN   on edge with Start=1 & Enable=0.
//       At that edge, latch A, B; borrow FF<=Bin0; count<=0.
//     RUN: each edge processes bit[count]:
//       d = a^b^br
//       bo = (~a&b)|(~(a^b)&br)
//       Shift d into the result shift register from the MSB end; br<=bo; count++.
//     RUN -> DONE  on the edge that processes bit WIDTH-1.
//       On that edge, Diff reg <= full result and Bout8 <= bo.
//     DONE -> IDLE on the next edge, unconditionally.
//   Latency: Start accepted at edge t -> Done high for exactly one cycle between edges
//     t+WIDTH and t+WIDTH+1. Busy is high between edges t and t+WIDTH.
//   Diff/Bout8 update only on the RUN->DONE edge; they hold until the next completion.
//   Start in RUN or DONE is ignored; no queueing.
//   Enable=1 while in RUN (abort):
//     - next edge goes to IDLE;
//     - no Done pulse;
//     - Diff reg and Bout8 keep their previous values.
//   Enable=1 while in IDLE: Start is ignored.
//   Diff output = Enable ? {WIDTH{1'bz}} : Diff reg. Bout8, Busy and Done are never tri-stated.
//   Arithmetic: unsigned modulo 2^WIDTH. Bout8=1 iff A < B + Bin0.
//   Operand inputs may change freely after the accepting edge.
// CONFIGURATION
//   SERIAL_SUB_OVERFLOW_EN defined:
//     - adds output Ovf (1 bit, reset 0);
//     - Ovf = signed overflow = br_into_msb ^ bo_out_of_msb;
//     - registered alongside Bout8 on the RUN->DONE edge and held with it.
//   Undefined: no Ovf port and no associated logic.
// STRUCTURE
//   Shared package arith_pkg holds:
//     - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//     - the count width function clog2.
//   One sub-module: full_subtractor_with_enable (a, b, bin, enable -> diff, bout).
//     Purely combinational; instantiated once and reused every cycle.
//   Top level contains the FSM, counter, operand shift registers, borrow FF and result register.
// TESTING
//   1) Rst, Enable=0, A=0x05 B=0x03 Bin0=0, Start pulse at edge t
//      -> Busy over t..t+8, Done at t+8, Diff=0x02, Bout8=0.
//   2) A=0x03 B=0x05 Bin0=0 -> Diff=0xFE, Bout8=1.
//      A=0x00 B=0x00 Bin0=1 -> Diff=0xFF, Bout8=1.
//   3) Start held high through RUN after A=0x10 B=0x01
//      -> exactly one result 0x0F, one Done pulse, re-accept only after IDLE.
//   4) Enable=1 at t+4 during a run
//      -> Diff='bz, returns to IDLE, no Done.
//      Drive Enable=0 again -> Diff shows prior result unchanged.
//   5) Rst=1 at t+3
//      -> next edge: Busy=0, Done=0, Diff=0x00, Bout8=0. New Start then completes normally.
//   6) With SERIAL_SUB_OVERFLOW_EN:
//      A=0x80 B=0x01 -> Diff=0x7F, Ovf=1, Bout8=0.
//      A=0x7F B=0xFF -> Diff=0x80, Ovf=1, Bout8=1.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: FSM state encoding and the counter-width helper.
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Bits needed to index 0..v-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_with_enable.sv
// One-bit full subtractor; outputs forced low when enable is deasserted.
module full_subtractor_with_enable (
    input  logic a,
    input  logic b,
    input  logic bin,
    input  logic enable,
    output logic diff,
    output logic bout
);

    assign diff = enable & (a ^ b ^ bin);
    assign bout = enable & ((~a & b) | (~(a ^ b) & bin));

endmodule

// File: rtl/eight_bit_serial_subtractor_with_enable.sv
// Bit-serial A - B - Bin0 subtractor, LSB first, one full-subtractor cell reused per clock.
// Optional signed-overflow output Ovf enabled by defining SERIAL_SUB_OVERFLOW_EN.
module eight_bit_serial_subtractor_with_enable
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin0,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout8,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             Ovf,
`endif
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = clog2(WIDTH);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic             cell_en_c;
    logic             d_c;
    logic             bo_c;
    logic             last_bit_c;

    assign cell_en_c  = (state == S_RUN) && !Enable;
    assign last_bit_c = (count == CW'(WIDTH - 1));

    full_subtractor_with_enable u_cell (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .bin    (br),
        .enable (cell_en_c),
        .diff   (d_c),
        .bout   (bo_c)
    );

    // State register plus registered Busy/Done decoded from the next state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_n;
            Busy  <= (state_n == S_RUN);
            Done  <= (state_n == S_DONE);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (Start && !Enable) state_n = S_RUN;
            S_RUN: begin
                if (Enable)          state_n = S_IDLE;
                else if (last_bit_c) state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Operand shifters, borrow FF, bit counter and result capture.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            diff_q <= '0;
            Bout8  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE && Start && !Enable) begin
                a_sh  <= A;
                b_sh  <= B;
                br    <= Bin0;
                count <= '0;
            end else if (cell_en_c) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= {d_c, res_sh[WIDTH-1:1]};
                br     <= bo_c;
                count  <= count + CW'(1);
                if (last_bit_c) begin
                    diff_q <= {d_c, res_sh[WIDTH-1:1]};
                    Bout8  <= bo_c;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    Ovf    <= br ^ bo_c;
`endif
                end
            end
        end
    end

    assign Diff = Enable ? {WIDTH{1'bz}} : diff_q;

endmodule

// File: tb/tb_eight_bit_serial_subtractor_with_enable.sv
// Directed self-checking bench for the serial subtractor (Ovf checks under SERIAL_SUB_OVERFLOW_EN).
module tb_eight_bit_serial_subtractor_with_enable;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin0;
    wire  [7:0] diff;
    logic       bout8;
    logic       busy;
    logic       done;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       ovf;
`endif

    int n_total;
    int n_bad;

    // Weak pull so a released bus reads as a defined 0 in 2-state simulation too.
    pulldown (diff);

    eight_bit_serial_subtractor_with_enable #(.WIDTH(8)) dut (
        .Clk    (clk),
        .Rst    (rst),
        .Enable (enable),
        .Start  (start),
        .A      (a),
        .B      (b),
        .Bin0   (bin0),
        .Diff   (diff),
        .Bout8  (bout8),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .Ovf    (ovf),
`endif
        .Busy   (busy),
        .Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full accepted operation: Busy across 8 edges, one Done pulse, then result held.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                          input logic [7:0] ed, input logic eb);
        a = va; b = vb; bin0 = vbin; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va; b = ~vb; bin0 = ~vbin;
        chk("busy_t0", 32'(busy), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) chk("run_flags", {30'd0, busy, done}, 32'd2);
        end
        tick();
        chk("done_pulse", {30'd0, busy, done}, 32'd1);
        chk("diff", 32'(diff), 32'(ed));
        chk("bout8", 32'(bout8), 32'(eb));
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("diff_hold", 32'(diff), 32'(ed));
    endtask

    initial begin
        int ndone;
        n_total = 0; n_bad = 0;
        rst = 1'b1; enable = 1'b0; start = 1'b0; a = '0; b = '0; bin0 = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        rst = 1'b0;
        tick();

        // Basic differences, including borrow-out cases.
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start held high: one result per pass through IDLE.
        a = 8'h10; b = 8'h01; bin0 = 1'b0; start = 1'b1;
        tick();
        ndone = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("held_one_done", 32'(ndone), 32'd1);
        chk("held_diff", 32'(diff), 32'h0F);
        chk("held_idle", 32'(busy), 32'd0);
        tick();
        chk("held_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        tick();
        chk("held_second_done", 32'(done), 32'd1);
        chk("held_second_diff", 32'(diff), 32'h0F);
        tick();

        // Make the held borrow nonzero before aborting.
        run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1);

        // Abort mid-run: tri-state, back to IDLE, no Done, result preserved.
        a = 8'h33; b = 8'h11; bin0 = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        enable = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff_z", 32'(diff), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        start = 1'b1;
        tick(); tick();
        chk("idle_disabled_ignore", 32'(busy), 32'd0);
        start = 1'b0;
        enable = 1'b0;
        #1;
        chk("abort_diff_kept", 32'(diff), 32'hFF);
        chk("abort_bout_kept", 32'(bout8), 32'd1);
        tick();

        // Reset mid-run dominates and clears everything.
        a = 8'h05; b = 8'h03; bin0 = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("mrst_flags", {30'd0, busy, done}, 32'd0);
        chk("mrst_diff", 32'(diff), 32'd0);
        chk("mrst_bout", 32'(bout8), 32'd0);
        rst = 1'b0;
        tick();
        run_op(8'h81, 8'h02, 1'b0, 8'h7F, 1'b0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        chk("ovf_80_01", 32'(ovf), 32'd1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
        chk("ovf_7f_ff", 32'(ovf), 32'd1);
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        chk("ovf_05_03", 32'(ovf), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
